// File: rtl/logic_sweep_pkg.sv
// Shared types and width helpers for the exhaustive logic sweep engine.
package logic_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

  function automatic int vec_w(input int n_in);
    return n_in;
  endfunction

  // One extra bit so a sweep in which every vector fails still fits.
  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int tt_w(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int hold_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/logic_sweep_engine_hold_timer.sv
// HOLD_CYCLES-modulo down-counter; last is high in the final cycle of each hold window.
module sweep_hold_timer
  import logic_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int HW = hold_w(HOLD_CYCLES);
  localparam logic [HW-1:0] LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] ONE  = HW'(1);

  logic [HW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? LOAD : cnt - ONE;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/logic_sweep_engine.sv
// Exhaustive sweep of an N_IN-input logic cell against a captured truth table.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; a one-cycle launch slot follows capture
//   RUN     | vec_out held HOLD_CYCLES cycles, response sampled at the end
//   DONE    | one-cycle done pulse, pass valid, then back to IDLE
module logic_sweep_engine
  import logic_sweep_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode_stop,
  input  logic [tt_w(N_IN)-1:0]    truth_table,
  input  logic                     dut_out,
  output logic [vec_w(N_IN)-1:0]   vec_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [cnt_w(N_IN)-1:0]   err_count,
  output logic [vec_w(N_IN)-1:0]   first_err_vec
);

  localparam int VEC_W = vec_w(N_IN);
  localparam int CNT_W = cnt_w(N_IN);
  localparam int TT_W  = tt_w(N_IN);

  localparam logic [VEC_W-1:0] VEC_ONE = VEC_W'(1);
  localparam logic [VEC_W-1:0] VEC_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sweep_state_e    state;
  logic [TT_W-1:0] tt_q;
  logic            mode_stop_q;
  logic            launch;
  logic            hold_last;
  logic            sample;
  logic            mismatch;
  logic            sweep_end;

  // Capture happens on the start edge; RUN is entered one edge later so vector 0
  // gets a full hold window that begins on a clean registered edge.
  sweep_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (launch),
    .en    (state == ST_RUN),
    .last  (hold_last)
  );

  assign sample    = (state == ST_RUN) && hold_last;
  assign mismatch  = sample && (dut_out != tt_q[vec_out]);
  assign sweep_end = sample && ((vec_out == VEC_MAX) || (mode_stop_q && mismatch));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      launch        <= 1'b0;
      tt_q          <= '0;
      mode_stop_q   <= 1'b0;
      vec_out       <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            launch <= 1'b0;
            state  <= ST_RUN;
          end else if (start) begin
            launch        <= 1'b1;
            tt_q          <= truth_table;
            mode_stop_q   <= mode_stop;
            vec_out       <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
          end
        end
        ST_RUN: begin
          if (mismatch) begin
            err_count <= err_count + CNT_ONE;
            if (err_count == '0) begin
              first_err_vec <= vec_out;
            end
          end
          if (sweep_end) begin
            state <= ST_DONE;
            pass  <= (err_count == '0) && !mismatch;
          end else if (sample) begin
            vec_out <= vec_out + VEC_ONE;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          vec_out <= '0;
        end
        default: begin
          state  <= ST_IDLE;
          launch <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: doc/logic_sweep_engine.md
# logic_sweep_engine

Sequential, parametrised exhaustive-test engine for small combinational logic blocks. It steps an N-bit input vector through all 2^N combinations, holds each for a programmable number of cycles, samples the 1-bit response of the attached logic and compares it against a captured expected truth table. It reports pass/fail, the mismatch count and the first failing vector. It sits beside any combinational logic cell in the design as an on-chip, synthesizable replacement for hand-written exhaustive stimulus.

## Interface
Parameters:
- N_IN, 4: number of logic inputs driven; legal range 1..8.
- HOLD_CYCLES, 1: cycles each vector is held before sampling; legal range ≥1.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- mode_stop  in  1  1 = terminate at first mismatch; captured with start.
- truth_table  in  2^N_IN  expected output for each vector (bit i = vector i); captured with start.
- dut_out  in  1  response of the logic under test.
- vec_out  out  N_IN  current input vector to the logic under test.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a sweep ends.
- pass  out  1  1 = last sweep had zero mismatches; held until next start.
- err_count  out  N_IN+1  mismatches in current/last sweep; cannot overflow.
- first_err_vec  out  N_IN  vector of the first mismatch; valid when err_count≠0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1: capture truth_table and mode_stop. Clear vec_out, hold counter, err_count, first_err_vec and pass. Go to RUN.
- RUN: vec_out held for HOLD_CYCLES cycles. On the last hold cycle, compare dut_out with tt_q[vec_out].
  - Mismatch: increment err_count. If err_count was 0, load first_err_vec with vec_out.
  - If vec_out = 2^N_IN−1, or (mode_stop_q and a mismatch occurred): go to DONE.
  - Otherwise: increment vec_out and restart the hold counter.
- DONE: done=1 for exactly one cycle; pass ← (err_count=0). Next state IDLE; vec_out returns to 0.
- start in RUN or DONE is ignored. truth_table and mode_stop changes after capture have no effect.
- Reset (any time, including mid-sweep): state IDLE, and every output is 0 (vec_out, busy, done, pass, err_count, first_err_vec). The next start runs a clean sweep.

## Timing
- start sampled at edge E. RUN begins at E+1 with vec_out=0.
- Vector i is on vec_out from edge E+1+i·HOLD_CYCLES. It is sampled at edge E+(i+1)·HOLD_CYCLES+1; err_count updates at that same edge.
- Full sweep: done is high during the cycle after edge E+2^N_IN·HOLD_CYCLES+1, i.e. 2^N_IN·HOLD_CYCLES+1 edges after the start edge. pass is valid from that edge.
- Early stop at vector k: done follows the edge that samples vector k.
- Back-to-back: start asserted during the done cycle is ignored. Earliest re-start is the first IDLE cycle.
- vec_out is registered. The attached logic has the full hold window to settle, so there are no combinational paths from input to output.

## Structure
- Package logic_sweep_pkg: state enum (IDLE/RUN/DONE), and width helpers VEC_W=N_IN, CNT_W=N_IN+1, TT_W=2^N_IN.
- One sub-module: sweep_hold_timer. It is a HOLD_CYCLES-modulo counter with clear and a last-cycle flag. The FSM, vector counter and comparator stay in the top.

## Test plan
Golden logic: f = (a^b)|(~a&c)|~(b&d) with a=vec[0], b=vec[1], c=vec[2], d=vec[3]; truth_table=0x77FF.
- N_IN=4, HOLD=1, correct f, mode_stop=0 → vec_out 0..15, done one cycle at 17 edges after start, pass=1, err_count=0.
- Same, logic with output stuck-1 → err_count=2, first_err_vec=11, pass=0.
- Stuck-1 logic, mode_stop=1 → sweep ends after vector 11 sampled; err_count=1, first_err_vec=11, done 13 edges after start.
- HOLD_CYCLES=3 → vec_out changes every 3 cycles, done 49 edges after start; start pulse mid-sweep ignored (vec_out sequence unchanged).
- rst_n low while vec_out=7 → all outputs 0 asynchronously. Restart gives a clean sweep with pass=1, err_count=0.
